// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if
//   Groups the producer/consumer side of sync_fifo_param.
//   master : drives wr_en, wr_data, rd_en, clr_err; observes data, level and flags
//   slave  : the FIFO itself
interface sync_fifo_param_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
);
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic              clr_err;
    logic [DATA_W-1:0] rd_data;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic              underflow;
    logic [15:0]       drop_cnt;

    modport master (
        output wr_en, wr_data, rd_en, clr_err,
        input  rd_data, empty, full, almost_full, almost_empty,
               level, overflow, underflow, drop_cnt
    );

    modport slave (
        input  wr_en, wr_data, rd_en, clr_err,
        output rd_data, empty, full, almost_full, almost_empty,
               level, overflow, underflow, drop_cnt
    );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param
//   Single-clock first-word-fall-through FIFO, 2^ADDR_W x DATA_W, with
//   occupancy level, almost-full/almost-empty thresholds, write protection
//   when full, sticky overflow/underflow flags and a saturating count of
//   dropped writes.
// Ports
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : slave side of sync_fifo_param_if (requests in, data/level/flags out)
module sync_fifo_param #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned AF_THRESH = 192,
    parameter int unsigned AE_THRESH = 16
) (
    input  logic                clk,
    input  logic                reset,
    sync_fifo_param_if.slave    bus
);
    localparam int unsigned     DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] C_DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] C_AF    = AF_THRESH[ADDR_W:0];
    localparam logic [ADDR_W:0] C_AE    = AE_THRESH[ADDR_W:0];

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]   r_wp;
    logic [ADDR_W:0]   r_rp;
    logic              r_overflow;
    logic              r_underflow;
    logic [15:0]       r_drop_cnt;

    logic [ADDR_W:0]   w_level;
    logic              w_empty;
    logic              w_full;
    logic              w_wr_ok;
    logic              w_wr_rej;
    logic              w_rd_ok;
    logic              w_rd_rej;

    // Extra wrap bit makes wp - rp an exact occupancy 0..DEPTH.
    assign w_level  = r_wp - r_rp;
    assign w_empty  = (w_level == '0);
    assign w_full   = (w_level == C_DEPTH);

    // Acceptance is decided on pre-edge occupancy only.
    assign w_wr_ok  = bus.wr_en && !w_full;
    assign w_wr_rej = bus.wr_en &&  w_full;
    assign w_rd_ok  = bus.rd_en && !w_empty;
    assign w_rd_rej = bus.rd_en &&  w_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[r_wp[ADDR_W-1:0]] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_wr_ok) r_wp <= r_wp + 1'b1;
            if (w_rd_ok) r_rp <= r_rp + 1'b1;
        end
    end

    // Error events win over a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_wr_rej)         r_overflow <= 1'b1;
            else if (bus.clr_err) r_overflow <= 1'b0;

            if (w_rd_rej)         r_underflow <= 1'b0 | 1'b1;
            else if (bus.clr_err) r_underflow <= 1'b0;

            if (w_wr_rej) begin
                if (bus.clr_err)                r_drop_cnt <= 16'd1;
                else if (r_drop_cnt != '1)      r_drop_cnt <= r_drop_cnt + 16'd1;
            end else if (bus.clr_err) begin
                r_drop_cnt <= '0;
            end
        end
    end

    assign bus.rd_data      = r_mem[r_rp[ADDR_W-1:0]];
    assign bus.empty        = w_empty;
    assign bus.full         = w_full;
    assign bus.almost_full  = (w_level >= C_AF);
    assign bus.almost_empty = (w_level <= C_AE);
    assign bus.level        = w_level;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
    assign bus.drop_cnt     = r_drop_cnt;
endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 8;

    logic clk;
    logic reset;
    int unsigned errors;
    int unsigned checks;

    sync_fifo_param_if #(.DATA_W(DW), .ADDR_W(AW)) fifo_if ();

    sync_fifo_param #(
        .DATA_W(DW), .ADDR_W(AW), .AF_THRESH(192), .AE_THRESH(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(fifo_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [31:0] d;
        logic        rd;
        logic        clr;
        logic [8:0]  lvl;
        logic [31:0] rdat;
        logic        emp;
        logic        ov;
        logic        un;
        logic [15:0] drop;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic wr, input logic [31:0] d, input logic rd, input logic clr);
        fifo_if.wr_en   = wr;
        fifo_if.wr_data = d;
        fifo_if.rd_en   = rd;
        fifo_if.clr_err = clr;
        @(posedge clk);
        #1;
        fifo_if.wr_en   = 1'b0;
        fifo_if.rd_en   = 1'b0;
        fifo_if.clr_err = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " empty"},    64'(fifo_if.empty), 64'd1);
        chk({tag, " full"},     64'(fifo_if.full), 64'd0);
        chk({tag, " level"},    64'(fifo_if.level), 64'd0);
        chk({tag, " ae"},       64'(fifo_if.almost_empty), 64'd1);
        chk({tag, " af"},       64'(fifo_if.almost_full), 64'd0);
        chk({tag, " rd_data"},  64'(fifo_if.rd_data), 64'd0);
        chk({tag, " overflow"}, 64'(fifo_if.overflow), 64'd0);
        chk({tag, " underflow"},64'(fifo_if.underflow), 64'd0);
        chk({tag, " drop_cnt"}, 64'(fifo_if.drop_cnt), 64'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        fifo_if.wr_en   = 1'b0;
        fifo_if.wr_data = '0;
        fifo_if.rd_en   = 1'b0;
        fifo_if.clr_err = 1'b0;

        //          wr  d       rd  clr lvl   rdat    emp ov  un  drop
        vecs[0]  = '{1'b1, 32'h11, 1'b0, 1'b0, 9'd1, 32'h11, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[1]  = '{1'b1, 32'h22, 1'b0, 1'b0, 9'd2, 32'h11, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[2]  = '{1'b1, 32'h33, 1'b0, 1'b0, 9'd3, 32'h11, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[3]  = '{1'b0, 32'h0,  1'b1, 1'b0, 9'd2, 32'h22, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[4]  = '{1'b0, 32'h0,  1'b1, 1'b0, 9'd1, 32'h33, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[5]  = '{1'b0, 32'h0,  1'b1, 1'b0, 9'd0, 32'h0,  1'b1, 1'b0, 1'b0, 16'd0};
        vecs[6]  = '{1'b0, 32'h0,  1'b1, 1'b0, 9'd0, 32'h0,  1'b1, 1'b0, 1'b1, 16'd0};
        vecs[7]  = '{1'b1, 32'h44, 1'b1, 1'b0, 9'd1, 32'h44, 1'b0, 1'b0, 1'b1, 16'd0};
        vecs[8]  = '{1'b0, 32'h0,  1'b0, 1'b1, 9'd1, 32'h44, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[9]  = '{1'b1, 32'h55, 1'b1, 1'b0, 9'd1, 32'h55, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[10] = '{1'b0, 32'h0,  1'b1, 1'b0, 9'd0, 32'h0,  1'b1, 1'b0, 1'b0, 16'd0};

        #2;
        chk_reset_outputs("por");
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].wr, vecs[i].d, vecs[i].rd, vecs[i].clr);
            chk($sformatf("vec%0d level", i),     64'(fifo_if.level),     64'(vecs[i].lvl));
            chk($sformatf("vec%0d rd_data", i),   64'(fifo_if.rd_data),   64'(vecs[i].rdat));
            chk($sformatf("vec%0d empty", i),     64'(fifo_if.empty),     64'(vecs[i].emp));
            chk($sformatf("vec%0d full", i),      64'(fifo_if.full),      64'd0);
            chk($sformatf("vec%0d overflow", i),  64'(fifo_if.overflow),  64'(vecs[i].ov));
            chk($sformatf("vec%0d underflow", i), 64'(fifo_if.underflow), 64'(vecs[i].un));
            chk($sformatf("vec%0d drop_cnt", i),  64'(fifo_if.drop_cnt),  64'(vecs[i].drop));
        end

        // Fill to DEPTH with thresholds checked at every level.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            step(1'b1, 32'(i), 1'b0, 1'b0);
            chk($sformatf("fill%0d level", i), 64'(fifo_if.level), 64'(i + 1));
            chk($sformatf("fill%0d ae", i), 64'(fifo_if.almost_empty), 64'((i + 1) <= 16));
            chk($sformatf("fill%0d af", i), 64'(fifo_if.almost_full), 64'((i + 1) >= 192));
        end
        chk("full flag", 64'(fifo_if.full), 64'd1);
        step(1'b1, 32'hBAD0, 1'b0, 1'b0);
        step(1'b1, 32'hBAD1, 1'b0, 1'b0);
        chk("ovf level", 64'(fifo_if.level), 64'd256);
        chk("ovf full", 64'(fifo_if.full), 64'd1);
        chk("ovf flag", 64'(fifo_if.overflow), 64'd1);
        chk("ovf drop", 64'(fifo_if.drop_cnt), 64'd2);
        chk("ovf head", 64'(fifo_if.rd_data), 64'd0);

        // Full with both requests: pop wins, push dropped.
        step(1'b1, 32'hDEAD, 1'b1, 1'b0);
        chk("fullrw level", 64'(fifo_if.level), 64'd255);
        chk("fullrw drop", 64'(fifo_if.drop_cnt), 64'd3);
        chk("fullrw head", 64'(fifo_if.rd_data), 64'd1);
        chk("fullrw full", 64'(fifo_if.full), 64'd0);

        for (int i = 1; i < 256; i++) begin
            chk($sformatf("drain%0d data", i), 64'(fifo_if.rd_data), 64'(i));
            step(1'b0, 32'h0, 1'b1, 1'b0);
        end
        chk("drain empty", 64'(fifo_if.empty), 64'd1);
        chk("drain level", 64'(fifo_if.level), 64'd0);

        // Empty with both requests: push wins, pop rejected.
        step(1'b1, 32'h77, 1'b1, 1'b0);
        chk("emptyrw level", 64'(fifo_if.level), 64'd1);
        chk("emptyrw underflow", 64'(fifo_if.underflow), 64'd1);
        chk("emptyrw head", 64'(fifo_if.rd_data), 64'h77);

        // Steady level of 5 across several pointer wraps.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 32'(1000 + i), 1'b0, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            chk($sformatf("wrap%0d head", i), 64'(fifo_if.rd_data), 64'(1000 + i));
            step(1'b1, 32'(1005 + i), 1'b1, 1'b0);
            chk($sformatf("wrap%0d level", i), 64'(fifo_if.level), 64'd5);
            chk($sformatf("wrap%0d full", i), 64'(fifo_if.full), 64'd0);
        end

        // clr_err racing a rejected write.
        for (int i = 0; i < 251; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        chk("refill full", 64'(fifo_if.full), 64'd1);
        step(1'b1, 32'h1, 1'b0, 1'b0);
        step(1'b1, 32'h2, 1'b0, 1'b0);
        chk("pre-clr drop", 64'(fifo_if.drop_cnt), 64'd2);
        step(1'b1, 32'h3, 1'b0, 1'b1);
        chk("clr+rej overflow", 64'(fifo_if.overflow), 64'd1);
        chk("clr+rej drop", 64'(fifo_if.drop_cnt), 64'd1);
        step(1'b0, 32'h0, 1'b0, 1'b1);
        chk("clr overflow", 64'(fifo_if.overflow), 64'd0);
        chk("clr drop", 64'(fifo_if.drop_cnt), 64'd0);

        // Asynchronous reset mid-fill with a pending write.
        do_reset();
        step(1'b0, 32'h0, 1'b1, 1'b0);
        chk("pre-rst underflow", 64'(fifo_if.underflow), 64'd1);
        for (int i = 0; i < 100; i++) step(1'b1, 32'(32'hA000 + i), 1'b0, 1'b0);
        chk("pre-rst level", 64'(fifo_if.level), 64'd100);
        #3;
        fifo_if.wr_en   = 1'b1;
        fifo_if.wr_data = 32'hFFFF;
        reset = 1'b0;
        #1;
        chk_reset_outputs("async");
        @(posedge clk);
        #1;
        chk("rst-held level", 64'(fifo_if.level), 64'd0);
        fifo_if.wr_en = 1'b0;
        reset = 1'b1;
        step(1'b0, 32'h0, 1'b0, 1'b0);
        chk_reset_outputs("post-rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
